// File: rtl/btn_cond_pkg.sv
// btn_cond_pkg: FSM states, button indices and priority helper shared by btn_pulse_conditioner.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int IDX_B3 = 2;
    localparam int IDX_B2 = 1;
    localparam int IDX_B0 = 0;

    // One-hot of the highest-priority request: btn_3 beats btn_2 beats btn_0
    function automatic logic [2:0] prio_onehot(input logic [2:0] req);
        return req[IDX_B3] ? 3'(1 << IDX_B3) :
               req[IDX_B2] ? 3'(1 << IDX_B2) :
               req[IDX_B0] ? 3'(1 << IDX_B0) : 3'b000;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stable-count debouncer and registered press (rising-level) flag.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic lvl,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          rise_q, rise_d;

    // Count consecutive disagreeing samples; the D-th one commits the new level
    always_comb begin
        sync_d = {sync_q[0], btn};
        lvl_d  = lvl_q;
        cnt_d  = '0;
        if (sync_q[1] != lvl_q) begin
            if (cnt_q == CNT_LAST) lvl_d = sync_q[1];
            else cnt_d = cnt_q + 1'b1;
        end
        rise_d = lvl_d & ~lvl_q;
    end

    // Synchroniser, counter, level and press flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
        end
    end

    assign lvl  = lvl_q;
    assign rise = rise_q;

endmodule

// File: rtl/btn_pulse_conditioner.sv
// btn_pulse_conditioner: debounced buttons -> one-at-a-time fixed-width pulses; BTN_COND_QUEUE_EN enables pending flags.
module btn_pulse_conditioner
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int PULSE_CYCLES    = 16,
    parameter int GAP_CYCLES      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_3,
    input  logic       btn_2,
    input  logic       btn_0,
    output logic       x1,
    output logic       x2,
    output logic       x3,
    output logic [2:0] lvl,
    output logic       busy,
    output logic       overrun
);
    localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    logic [2:0]    btn_raw, rise, req, gnt;
    logic          arb;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    x_q, x_d;
    logic          overrun_q, overrun_d;
`ifdef BTN_COND_QUEUE_EN
    logic [2:0]    pend_q, pend_d;
`endif

    assign btn_raw = {btn_3, btn_2, btn_0};

    for (genvar i = 0; i < 3; i++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_raw[i]),
            .lvl  (lvl[i]),
            .rise (rise[i])
        );
    end

    // Arbiter: grant in IDLE or the last GAP cycle so a waiting press follows after exactly GAP_CYCLES
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        arb       = (state_q == ST_IDLE) || (state_q == ST_GAP && cnt_q == GAP_LAST);
`ifdef BTN_COND_QUEUE_EN
        req       = rise | pend_q;
`else
        req       = rise;
`endif
        gnt       = arb ? prio_onehot(req) : 3'b000;
        unique case (state_q)
            ST_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    x_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP:   cnt_d = (cnt_q == GAP_LAST) ? cnt_q : cnt_q + 1'b1;
            default:  ;
        endcase
        if (arb) begin
            state_d = (|gnt) ? ST_PULSE : ST_IDLE;
            cnt_d   = '0;
            x_d     = gnt;
        end
`ifdef BTN_COND_QUEUE_EN
        pend_d    = (pend_q | rise) & ~gnt;
        overrun_d = overrun_q | (|(rise & pend_q));
`else
        overrun_d = overrun_q | (|(rise & ~gnt));
`endif
    end

    // State, counter, pulse outputs, pending flags and sticky overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            x_q       <= '0;
            overrun_q <= 1'b0;
`ifdef BTN_COND_QUEUE_EN
            pend_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            overrun_q <= overrun_d;
`ifdef BTN_COND_QUEUE_EN
            pend_q    <= pend_d;
`endif
        end
    end

    assign x1      = x_q[IDX_B3];
    assign x2      = x_q[IDX_B2];
    assign x3      = x_q[IDX_B0];
    assign busy    = (state_q != ST_IDLE);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_btn_pulse_conditioner.sv
// tb_btn_pulse_conditioner: vector table, corner-case sequences and randomized run against an edge-timeline model.
module tb_btn_pulse_conditioner;
    localparam int D = 4;
    localparam int P = 3;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_3 = 1'b0, btn_2 = 1'b0, btn_0 = 1'b0;
    logic       x1, x2, x3, busy, overrun;
    logic [2:0] lvl;
    int         tests = 0, fails = 0;

    btn_pulse_conditioner #(
        .DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .GAP_CYCLES(G)
    ) dut (
        .clk(clk), .rst(rst), .btn_3(btn_3), .btn_2(btn_2), .btn_0(btn_0),
        .x1(x1), .x2(x2), .x3(x3), .lvl(lvl), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Reference model: raw-sample history, level flips after D equal differing samples,
    // pulses scheduled on an edge timeline (start edge, next free edge)
    logic [2:0] hist[$];
    logic [2:0] m_lvl, m_arr, m_pend, m_sel, m_x;
    logic       m_ovr, m_busy;
    int         n, m_start, next_free;
    int         cnt_x[3];
    logic [2:0] prev_x, lvl_or;

    typedef struct {
        logic [2:0] mask;
        int         hold;
        int         reps;
        int         n1, n2, n3;
        logic       ovr;
        logic [2:0] lvl;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        repeat (D + 2) hist.push_back(3'b000);
        m_lvl = '0; m_arr = '0; m_pend = '0; m_sel = '0; m_x = '0;
        m_ovr = 1'b0; m_busy = 1'b0;
        n = 0; m_start = -100; next_free = 0;
        prev_x = '0;
    endtask

    task automatic model_edge();
        logic [2:0] arr, cand, pick;
        int sz;
        bit all_diff;
        n++;
        arr = m_arr;
        if (n >= next_free) begin
`ifdef BTN_COND_QUEUE_EN
            m_ovr = m_ovr | (|(arr & m_pend));
            cand = arr | m_pend;
`else
            cand = arr;
`endif
            pick = '0;
            for (int b = 2; b >= 0; b--) if (cand[b] && pick == 3'b000) pick[b] = 1'b1;
            if (pick != 3'b000) begin
                m_start = n; m_sel = pick; next_free = n + P + G;
            end
`ifdef BTN_COND_QUEUE_EN
            m_pend = cand & ~pick;
`else
            m_ovr = m_ovr | (|(cand & ~pick));
`endif
        end else begin
`ifdef BTN_COND_QUEUE_EN
            m_ovr = m_ovr | (|(arr & m_pend));
            m_pend = m_pend | arr;
`else
            m_ovr = m_ovr | (|arr);
`endif
        end
        hist.push_back({btn_3, btn_2, btn_0});
        sz = hist.size();
        m_arr = '0;
        for (int b = 0; b < 3; b++) begin
            all_diff = 1'b1;
            for (int j = 0; j < D; j++) if (hist[sz - 3 - j][b] == m_lvl[b]) all_diff = 1'b0;
            if (all_diff) begin
                m_lvl[b] = ~m_lvl[b];
                m_arr[b] = m_lvl[b];
            end
        end
        void'(hist.pop_front());
        m_x    = (n >= m_start && n < m_start + P) ? m_sel : 3'b000;
        m_busy = (n >= m_start && n < m_start + P + G);
    endtask

    task automatic tick();
        logic [2:0] xv;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        xv = {x1, x2, x3};
        chk("x", 32'(xv), 32'(m_x));
        chk("lvl", 32'(lvl), 32'(m_lvl));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("onehot", 32'($countones(xv) <= 1), 32'd1);
        for (int b = 0; b < 3; b++) if (xv[b] && !prev_x[b]) cnt_x[b]++;
        prev_x = xv;
        lvl_or = lvl_or | lvl;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {btn_3, btn_2, btn_0} = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("reset outputs", 32'({x1, x2, x3, busy, overrun, lvl}), 32'd0);
    endtask

    initial begin
        int lat, wid, bsy, f, r, k;
        logic px;
        int left[3];
        logic [2:0] v;

        vecs[0] = '{3'b100, 20, 1, 1, 0, 0, 1'b0, 3'b100};
        vecs[1] = '{3'b010, 3, 1, 0, 0, 0, 1'b0, 3'b000};
        vecs[2] = '{3'b001, 4, 1, 0, 0, 1, 1'b0, 3'b001};
`ifdef BTN_COND_QUEUE_EN
        vecs[3] = '{3'b101, 30, 1, 1, 0, 1, 1'b0, 3'b101};
        vecs[4] = '{3'b111, 30, 1, 1, 1, 1, 1'b0, 3'b111};
`else
        vecs[3] = '{3'b101, 30, 1, 1, 0, 0, 1'b1, 3'b101};
        vecs[4] = '{3'b111, 30, 1, 1, 0, 0, 1'b1, 3'b111};
`endif
        vecs[5] = '{3'b001, 100, 2, 0, 0, 2, 1'b0, 3'b001};
        vecs[6] = '{3'b110, 1, 1, 0, 0, 0, 1'b0, 3'b000};

        foreach (vecs[i]) begin
            do_reset();
            cnt_x = '{0, 0, 0};
            lvl_or = '0;
            for (int rp = 0; rp < vecs[i].reps; rp++) begin
                {btn_3, btn_2, btn_0} = vecs[i].mask;
                repeat (vecs[i].hold) tick();
                {btn_3, btn_2, btn_0} = 3'b000;
                repeat (40) tick();
            end
            chk($sformatf("vec%0d x1 pulses", i), cnt_x[2], vecs[i].n1);
            chk($sformatf("vec%0d x2 pulses", i), cnt_x[1], vecs[i].n2);
            chk($sformatf("vec%0d x3 pulses", i), cnt_x[0], vecs[i].n3);
            chk($sformatf("vec%0d overrun", i), 32'(overrun), 32'(vecs[i].ovr));
            chk($sformatf("vec%0d lvl seen", i), 32'(lvl_or), 32'(vecs[i].lvl));
        end

        do_reset();
        btn_3 = 1'b1;
        lat = -1; wid = 0; bsy = 0;
        for (int kk = 1; kk <= 20; kk++) begin
            tick();
            if (x1 && lat < 0) lat = kk;
            wid += int'(x1);
            bsy += int'(busy);
        end
        chk("latency", lat, 7);
        chk("pulse width", wid, 3);
        chk("busy cycles", bsy, 5);
        chk("held lvl", 32'(lvl), 32'(3'b100));

        do_reset();
        btn_3 = 1'b1; btn_0 = 1'b1;
        f = -1; r = -1; px = 1'b0;
        for (int kk = 1; kk <= 30; kk++) begin
            tick();
            if (px && !x1 && f < 0) f = kk;
            if (x3 && r < 0) r = kk;
            px = x1;
        end
`ifdef BTN_COND_QUEUE_EN
        chk("simul x3 after x1 fall", r - f, 2);
        chk("simul overrun", 32'(overrun), 0);
`else
        chk("simul x3 start", r, -1);
        chk("simul overrun", 32'(overrun), 1);
`endif

        do_reset();
        btn_0 = 1'b1;
        tick(); tick();
        btn_2 = 1'b1;
        f = -1; r = -1; px = 1'b0;
        for (int kk = 3; kk <= 30; kk++) begin
            tick();
            if (px && !x3 && f < 0) f = kk;
            if (x2 && r < 0) r = kk;
            px = x3;
        end
`ifdef BTN_COND_QUEUE_EN
        chk("queued x2 after x3 fall", r - f, 2);
        chk("queued overrun", 32'(overrun), 0);
`else
        chk("dropped x2 start", r, -1);
        chk("dropped overrun", 32'(overrun), 1);
`endif

        do_reset();
        btn_3 = 1'b1;
        k = 0;
        while (!x1 && k < 20) begin
            tick();
            k++;
        end
        chk("rst test x1 rise", 32'(x1), 1);
        tick();
        chk("rst test x1 second cycle", 32'(x1), 1);
        #2 rst = 1'b1;
        #1;
        chk("async rst x1", 32'(x1), 0);
        chk("async rst busy", 32'(busy), 0);
        chk("async rst lvl", 32'(lvl), 0);
        chk("async rst overrun", 32'(overrun), 0);
        model_reset();

        do_reset();
        left = '{0, 0, 0};
        for (int c = 0; c < 4000; c++) begin
            if (c % 1000 == 999) do_reset();
            for (int b = 0; b < 3; b++) begin
                if (left[b] == 0) begin
                    v = {btn_3, btn_2, btn_0};
                    v[b] = ~v[b];
                    {btn_3, btn_2, btn_0} = v;
                    left[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(D, 40))
                                                          : int'($urandom_range(1, D + 1));
                end else begin
                    left[b]--;
                end
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
